// File: rtl/hht_col_update.sv
// Householder column update: streams x and v, accumulates v.x, then writes
// y = x - beta*v with beta = 2*(v.x), scaled by FRAC_W and saturated to DATA_W.
module hht_col_update #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int ACC_W  = 64,
  parameter int FRAC_W = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [LEN_W-1:0]  csize,
  output logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dataIn1,
  output logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] dataIn2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ACC_W-1:0]  dot_out,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DOT    = 3'd1;
  localparam logic [2:0] S_SCALE  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]               r_state;
  logic [ADDR_W-1:0]        r_col_base;
  logic [ADDR_W-1:0]        r_v_base;
  logic [ADDR_W-1:0]        r_out_base;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_beta;
  logic [ADDR_W-1:0]        r_addr1;
  logic [ADDR_W-1:0]        r_addr2;
  logic                     r_wr_en;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [DATA_W-1:0]        r_wr_data;
  logic [ACC_W-1:0]         r_dot;

  logic signed [DATA_W-1:0]   w_mul_a;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W:0]      w_beta_full;
  logic signed [DATA_W-1:0]   w_beta_sat;
  logic [DATA_W-1:0]          w_y;
  logic                       w_last;

  // One multiplier serves both phases: x*v while accumulating, beta*v while updating.
  always_comb begin
    w_mul_a     = (r_state == S_UPDATE) ? r_beta : $signed(dataIn1);
    w_prod      = (2*DATA_W)'(w_mul_a) * (2*DATA_W)'($signed(dataIn2));
    w_prod_ext  = ACC_W'(w_prod);
    w_beta_full = $signed({r_acc, 1'b0}) >>> FRAC_W;
    if (w_beta_full > SAT_MAX) begin
      w_beta_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_beta_full < SAT_MIN) begin
      w_beta_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      w_beta_sat = w_beta_full[DATA_W-1:0];
    end
    w_y    = dataIn1 - DATA_W'(w_prod >>> FRAC_W);
    w_last = (r_idx == r_len - LEN_W'(1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_col_base <= '0;
      r_v_base   <= '0;
      r_out_base <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_beta     <= '0;
      r_addr1    <= '0;
      r_addr2    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_dot      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_en <= 1'b0;
          if (start) begin
            r_col_base <= col_base;
            r_v_base   <= v_base;
            r_out_base <= out_base;
            r_len      <= csize;
            if (csize != '0) begin
              r_idx   <= '0;
              r_acc   <= '0;
              r_addr1 <= col_base;
              r_addr2 <= v_base;
              r_state <= S_DOT;
            end else begin
              r_dot   <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DOT: begin
          r_acc   <= r_acc + w_prod_ext;
          r_addr1 <= r_addr1 + ADDR_W'(1);
          r_addr2 <= r_addr2 + ADDR_W'(1);
          r_idx   <= r_idx + LEN_W'(1);
          if (w_last) begin
            r_state <= S_SCALE;
          end
        end
        S_SCALE: begin
          r_dot   <= r_acc;
          r_beta  <= w_beta_sat;
          r_addr1 <= r_col_base;
          r_addr2 <= r_v_base;
          r_idx   <= '0;
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_out_base + ADDR_W'(r_idx);
          r_wr_data <= w_y;
          r_addr1   <= r_addr1 + ADDR_W'(1);
          r_addr2   <= r_addr2 + ADDR_W'(1);
          r_idx     <= r_idx + LEN_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_wr_en <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign addr1   = r_addr1;
  assign addr2   = r_addr2;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign dot_out = r_dot;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_hht_col_update.sv
// Bench for hht_col_update: a wide FRAC_W=0 instance and a narrow saturating
// FRAC_W=15 instance, both checked against an arithmetic reference model.
module tb_hht_col_update;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst;
  logic        st [2];
  logic [31:0] cb [2];
  logic [31:0] vb [2];
  logic [31:0] ob [2];
  logic [15:0] cs [2];
  logic [31:0] m1 [2][256];
  logic [31:0] m2 [2][256];

  logic [31:0] a1_0, a2_0, wa_0, wd_0, di1_0, di2_0;
  logic [63:0] dot_0;
  logic        we_0, bsy_0, dn_0;
  logic [7:0]  a1_1, a2_1, wa_1;
  logic [15:0] wd_1, di1_1, di2_1;
  logic [39:0] dot_1;
  logic        we_1, bsy_1, dn_1;

  assign di1_0 = m1[0][a1_0[7:0]];
  assign di2_0 = m2[0][a2_0[7:0]];
  assign di1_1 = m1[1][a1_1][15:0];
  assign di2_1 = m2[1][a2_1][15:0];

  hht_col_update dut0 (
    .Clk(Clk), .Rst(Rst), .start(st[0]),
    .col_base(cb[0]), .v_base(vb[0]), .out_base(ob[0]), .csize(cs[0]),
    .addr1(a1_0), .dataIn1(di1_0), .addr2(a2_0), .dataIn2(di2_0),
    .wr_en(we_0), .wr_addr(wa_0), .wr_data(wd_0), .dot_out(dot_0),
    .busy(bsy_0), .done(dn_0)
  );

  hht_col_update #(.DATA_W(16), .ADDR_W(8), .LEN_W(8), .ACC_W(40), .FRAC_W(15)) dut1 (
    .Clk(Clk), .Rst(Rst), .start(st[1]),
    .col_base(cb[1][7:0]), .v_base(vb[1][7:0]), .out_base(ob[1][7:0]), .csize(cs[1][7:0]),
    .addr1(a1_1), .dataIn1(di1_1), .addr2(a2_1), .dataIn2(di2_1),
    .wr_en(we_1), .wr_addr(wa_1), .wr_data(wd_1), .dot_out(dot_1),
    .busy(bsy_1), .done(dn_1)
  );

  logic                 we [2];
  logic                 bsy [2];
  logic                 dn [2];
  logic [31:0]          wa [2];
  logic [31:0]          a1n [2];
  logic signed [127:0]  wdn [2];
  logic signed [127:0]  dotn [2];

  assign we[0]   = we_0;
  assign we[1]   = we_1;
  assign bsy[0]  = bsy_0;
  assign bsy[1]  = bsy_1;
  assign dn[0]   = dn_0;
  assign dn[1]   = dn_1;
  assign wa[0]   = wa_0;
  assign wa[1]   = {24'b0, wa_1};
  assign a1n[0]  = a1_0;
  assign a1n[1]  = {24'b0, a1_1};
  assign wdn[0]  = 128'($signed(wd_0));
  assign wdn[1]  = 128'($signed(wd_1));
  assign dotn[0] = 128'($signed(dot_0));
  assign dotn[1] = 128'($signed(dot_1));

  // Write monitor and activity counters, sampled on the falling edge.
  logic [31:0]         qa0 [$];
  logic [31:0]         qa1 [$];
  logic signed [127:0] qd0 [$];
  logic signed [127:0] qd1 [$];
  int bc [2] = '{0, 0};
  int dc [2] = '{0, 0};

  always @(negedge Clk) begin
    if (we[0]) begin qa0.push_back(wa[0]); qd0.push_back(wdn[0]); end
    if (we[1]) begin qa1.push_back(wa[1]); qd1.push_back(wdn[1]); end
    for (int d = 0; d < 2; d++) begin
      if (bsy[d]) bc[d]++;
      if (dn[d])  dc[d]++;
    end
  end

  function automatic int nw(input int d);
    return (d == 0) ? qa0.size() : qa1.size();
  endfunction

  function automatic logic [31:0] get_a(input int d, input int i);
    return (d == 0) ? qa0[i] : qa1[i];
  endfunction

  function automatic logic signed [127:0] get_d(input int d, input int i);
    return (d == 0) ? qd0[i] : qd1[i];
  endfunction

  int compares = 0;
  int fails    = 0;

  task automatic chk(input string tag, input logic signed [127:0] obs, input logic signed [127:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed arithmetic with explicit wrap and clamp.
  function automatic logic signed [127:0] wrapw(input logic signed [127:0] a, input int w);
    logic signed [127:0] m;
    m = a & ((128'sd1 <<< w) - 128'sd1);
    if (m[w-1]) m = m - (128'sd1 <<< w);
    return m;
  endfunction

  function automatic logic signed [127:0] sx(input logic [31:0] v, input int w);
    return wrapw({96'b0, v}, w);
  endfunction

  function automatic logic [31:0] rnd(input int mode);
    if (mode == 1) return $urandom;
    return 32'($urandom_range(200)) - 32'd100;
  endfunction

  logic [31:0]         exp_a [$];
  logic signed [127:0] exp_d [$];
  logic signed [127:0] exp_dot;

  task automatic model(input int d, input int n, input logic [31:0] cbase,
                       input logic [31:0] vbase, input logic [31:0] obase);
    int dw, fw, aw;
    logic signed [127:0] acc, beta, lim, x, v;
    dw = (d == 0) ? 32 : 16;
    fw = (d == 0) ? 0 : 15;
    aw = (d == 0) ? 64 : 40;
    exp_a.delete();
    exp_d.delete();
    acc = 0;
    for (int i = 0; i < n; i++)
      acc += sx(m1[d][8'(cbase + 32'(i))], dw) * sx(m2[d][8'(vbase + 32'(i))], dw);
    acc = wrapw(acc, aw);
    exp_dot = acc;
    beta = (acc * 2) >>> fw;
    lim  = 128'sd1 <<< (dw - 1);
    if (beta > lim - 1) beta = lim - 1;
    else if (beta < -lim) beta = -lim;
    for (int i = 0; i < n; i++) begin
      x = sx(m1[d][8'(cbase + 32'(i))], dw);
      v = sx(m2[d][8'(vbase + 32'(i))], dw);
      exp_d.push_back(wrapw(x - wrapw((beta * v) >>> fw, dw), dw));
      exp_a.push_back((d == 0) ? obase + 32'(i) : {24'b0, 8'(obase + 32'(i))});
    end
  endtask

  // One full operation; mode 2 means the caller preloaded the operands.
  task automatic run(input int d, input int n, input logic [31:0] cbase,
                     input logic [31:0] vbase, input logic [31:0] obase, input int mode);
    int w0, b0, d0, k;
    bit seen;
    if (mode != 2) begin
      for (int i = 0; i < n; i++) begin
        m1[d][8'(cbase + 32'(i))] = rnd(mode);
        m2[d][8'(vbase + 32'(i))] = rnd(mode);
      end
    end
    model(d, n, cbase, vbase, obase);
    @(negedge Clk); #1;
    w0 = nw(d); b0 = bc[d]; d0 = dc[d];
    cb[d] = cbase; vb[d] = vbase; ob[d] = obase; cs[d] = 16'(n); st[d] = 1'b1;
    @(posedge Clk); #1;
    st[d] = 1'b0;
    cb[d] = $urandom; vb[d] = $urandom; ob[d] = $urandom; cs[d] = 16'($urandom);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 4*n + 8) begin
      @(negedge Clk); #1;
      k++;
      seen = dn[d];
    end
    chk("done_seen", 128'(seen), 1);
    chk("done_latency", k, (n == 0) ? 1 : 2*n + 2);
    @(negedge Clk); #1;
    chk("busy_after_done", 128'(bsy[d]), 0);
    chk("write_count", nw(d) - w0, n);
    chk("done_pulses", dc[d] - d0, 1);
    chk("busy_cycles", bc[d] - b0, (n == 0) ? 1 : 2*n + 2);
    chk("dot_out", dotn[d], exp_dot);
    for (int i = 0; i < n && w0 + i < nw(d); i++) begin
      chk("wr_addr", get_a(d, w0 + i), exp_a[i]);
      chk("wr_data", get_d(d, w0 + i), exp_d[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, k;
    Rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; cb[d] = '0; vb[d] = '0; ob[d] = '0; cs[d] = '0;
      for (int i = 0; i < 256; i++) begin m1[d][i] = '0; m2[d][i] = '0; end
    end
    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;
    chk("rst_addr1", a1n[0], 0);
    chk("rst_addr2", a2_0, 0);
    chk("rst_wr_en", 128'(we[0]), 0);
    chk("rst_wr_addr", wa[0], 0);
    chk("rst_wr_data", wdn[0], 0);
    chk("rst_dot", dotn[0], 0);
    chk("rst_busy", 128'(bsy[0]), 0);
    chk("rst_done", 128'(dn[0]), 0);
    chk("rst1_wr_en", 128'(we[1]), 0);
    chk("rst1_busy", 128'(bsy[1]), 0);
    Rst = 1'b0;

    // Basic four-element case with known results.
    m1[0][16] = 5;  m1[0][17] = 15; m1[0][18] = 6;  m1[0][19] = 12;
    m2[0][64] = 33; m2[0][65] = 36; m2[0][66] = 35; m2[0][67] = 0;
    w0 = nw(0);
    run(0, 4, 16, 64, 128, 2);
    chk("basic_dot", dotn[0], 915);
    chk("basic_y0", get_d(0, w0), -60385);
    chk("basic_y1", get_d(0, w0 + 1), -65865);
    chk("basic_y2", get_d(0, w0 + 2), -64044);
    chk("basic_y3", get_d(0, w0 + 3), 12);

    m1[0][20] = 7; m2[0][70] = 1;
    w0 = nw(0);
    run(0, 1, 20, 70, 200, 2);
    chk("single_dot", dotn[0], 7);
    chk("single_y", get_d(0, w0), -7);

    run(0, 0, 30, 80, 220, 0);

    // Narrow instance: beta clamps to the positive limit.
    m1[1][10] = 32767; m2[1][20] = 32767;
    w0 = nw(1);
    run(1, 1, 10, 20, 30, 2);
    chk("sat_y", get_d(1, w0), 1);

    for (int t = 0; t < 6; t++)
      run(0, $urandom_range(1, 8), $urandom_range(0, 40), $urandom_range(60, 100),
          $urandom, t % 2);
    for (int t = 0; t < 4; t++)
      run(1, $urandom_range(1, 12), 240 + $urandom_range(15), $urandom_range(100, 140),
          250 + $urandom_range(5), 1);
    run(0, 4, 32'hFFFF_FFFE, 32'h0000_0080, 32'hFFFF_FFFE, 0);

    // Reset during the update phase: no further writes, no done pulse.
    for (int i = 0; i < 4; i++) begin m1[0][40 + i] = rnd(0); m2[0][90 + i] = rnd(0); end
    @(negedge Clk); #1;
    w0 = nw(0); d0 = dc[0];
    cb[0] = 40; vb[0] = 90; ob[0] = 0; cs[0] = 4; st[0] = 1'b1;
    @(posedge Clk); #1;
    st[0] = 1'b0;
    k = 0;
    while (nw(0) - w0 < 2 && k < 30) begin @(negedge Clk); #1; k++; end
    chk("rst_mid_two_writes", nw(0) - w0, 2);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rst_mid_wr_en", 128'(we[0]), 0);
    chk("rst_mid_busy", 128'(bsy[0]), 0);
    chk("rst_mid_done", 128'(dn[0]), 0);
    chk("rst_mid_dot", dotn[0], 0);
    Rst = 1'b0;
    repeat (12) @(negedge Clk);
    #1;
    chk("rst_mid_no_done", dc[0] - d0, 0);
    chk("rst_mid_no_more_writes", nw(0) - w0, 2);
    run(0, 4, 40, 90, 0, 2);

    // Start held high: two back-to-back operations, each writing n words.
    for (int i = 0; i < 3; i++) begin m1[0][100 + i] = rnd(0); m2[0][150 + i] = rnd(0); end
    model(0, 3, 100, 150, 300);
    @(negedge Clk); #1;
    w0 = nw(0); d0 = dc[0];
    cb[0] = 100; vb[0] = 150; ob[0] = 300; cs[0] = 3; st[0] = 1'b1;
    k = 0;
    while (dc[0] - d0 < 2 && k < 60) begin @(negedge Clk); #1; k++; end
    st[0] = 1'b0;
    chk("hold_two_dones", dc[0] - d0, 2);
    repeat (10) @(negedge Clk);
    #1;
    chk("hold_done_total", dc[0] - d0, 2);
    chk("hold_write_count", nw(0) - w0, 6);
    chk("hold_dot", dotn[0], exp_dot);
    for (int i = 0; i < 6 && w0 + i < nw(0); i++) begin
      chk("hold_wr_addr", get_a(0, w0 + i), exp_a[i % 3]);
      chk("hold_wr_data", get_d(0, w0 + i), exp_d[i % 3]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
